// File: rtl/fft_frame_feeder.sv
// rtl/fft_frame_feeder.sv - ping-pong frame buffer that bursts complete ADC frames into an FFT core
module fft_frame_feeder #(
  parameter int DATA_W   = 12,
  parameter int LOG2_LEN = 10,
  parameter int FFT_LEN  = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATA_W-1:0]   adc_data,
  input  logic                adc_valid,
  input  logic                fft_ready,
  output logic                fft_start,
  output logic                fft_valid,
  output logic [DATA_W-1:0]   fft_data,
  output logic [LOG2_LEN-1:0] fft_idx,
  output logic                fft_sop,
  output logic                fft_eop,
  output logic [15:0]         drop_cnt,
  output logic [15:0]         frame_cnt
);

  localparam logic [LOG2_LEN-1:0] LAST = LOG2_LEN'(FFT_LEN - 1);

  typedef enum logic [1:0] {IDLE, START, STREAM} state_t;

  logic [DATA_W-1:0]   mem_q [2*FFT_LEN];

  logic                wr_bank_q, wr_bank_d;
  logic [LOG2_LEN-1:0] wr_ptr_q, wr_ptr_d;
  logic                hold_q, hold_d;
  logic [1:0]          full_q, full_d;
  logic [15:0]         drop_cnt_q, drop_cnt_d;

  state_t              state_q;
  logic                rd_bank_q;
  logic                start_q, valid_q, sop_q, eop_q;
  logic [LOG2_LEN-1:0] idx_q;
  logic [DATA_W-1:0]   data_q;
  logic [15:0]         frame_cnt_q;

  logic                other_bank, rel, hold_exit, wr_en, wr_sel, other_free;
  logic                rd_avail, rd_pick, rd_en;
  logic [LOG2_LEN-1:0] rd_ptr;

  assign other_bank = ~wr_bank_q;
  assign rel        = (state_q == STREAM) && eop_q;
  // HOLD ends once the released bank shows empty; that cycle's sample lands at address 0 of it
  assign hold_exit  = hold_q && !full_q[other_bank];
  assign wr_en      = adc_valid && (!hold_q || hold_exit);
  assign wr_sel     = hold_q ? other_bank : wr_bank_q;
  assign other_free = !full_q[other_bank] || (rel && (rd_bank_q == other_bank));

  // Outside HOLD the write bank is never full, so the other bank is the oldest full one
  assign rd_avail = full_q[other_bank] || (hold_q && full_q[wr_bank_q]);
  assign rd_pick  = full_q[other_bank] ? other_bank : wr_bank_q;
  assign rd_en    = (state_q == START) || ((state_q == STREAM) && !eop_q);
  assign rd_ptr   = (state_q == START) ? '0 : LOG2_LEN'(idx_q + 1'b1);

  always_comb begin
    wr_bank_d  = wr_bank_q;
    wr_ptr_d   = wr_ptr_q;
    hold_d     = hold_q;
    full_d     = full_q;
    drop_cnt_d = drop_cnt_q;
    if (rel) full_d[rd_bank_q] = 1'b0;
    if (hold_exit) begin
      hold_d    = 1'b0;
      wr_bank_d = other_bank;
      wr_ptr_d  = adc_valid ? LOG2_LEN'(1) : '0;
    end else if (hold_q) begin
      if (adc_valid && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
    end else if (adc_valid) begin
      if (wr_ptr_q == LAST) begin
        full_d[wr_bank_q] = 1'b1;
        wr_ptr_d          = '0;
        if (other_free) wr_bank_d = other_bank;
        else            hold_d    = 1'b1;
      end else begin
        wr_ptr_d = LOG2_LEN'(wr_ptr_q + 1'b1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank_q  <= 1'b0;
      wr_ptr_q   <= '0;
      hold_q     <= 1'b0;
      full_q     <= 2'b00;
      drop_cnt_q <= '0;
    end else begin
      wr_bank_q  <= wr_bank_d;
      wr_ptr_q   <= wr_ptr_d;
      hold_q     <= hold_d;
      full_q     <= full_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[{wr_sel, wr_ptr_q}] <= adc_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rd_bank_q   <= 1'b0;
      start_q     <= 1'b0;
      valid_q     <= 1'b0;
      sop_q       <= 1'b0;
      eop_q       <= 1'b0;
      idx_q       <= '0;
      data_q      <= '0;
      frame_cnt_q <= '0;
    end else begin
      data_q  <= rd_en ? mem_q[{rd_bank_q, rd_ptr}] : '0;
      start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (fft_ready && rd_avail) begin
            state_q   <= START;
            rd_bank_q <= rd_pick;
            start_q   <= 1'b1;
          end
        end
        START: begin
          state_q <= STREAM;
          valid_q <= 1'b1;
          idx_q   <= '0;
          sop_q   <= 1'b1;
          eop_q   <= 1'b0;
        end
        STREAM: begin
          if (eop_q) begin
            state_q     <= IDLE;
            valid_q     <= 1'b0;
            idx_q       <= '0;
            sop_q       <= 1'b0;
            eop_q       <= 1'b0;
            frame_cnt_q <= frame_cnt_q + 16'd1;
          end else begin
            idx_q <= LOG2_LEN'(idx_q + 1'b1);
            sop_q <= 1'b0;
            eop_q <= (LOG2_LEN'(idx_q + 1'b1) == LAST);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_en && (state_q != IDLE)) assert (wr_sel != rd_bank_q);
  end

  assign fft_start = start_q;
  assign fft_valid = valid_q;
  assign fft_data  = data_q;
  assign fft_idx   = idx_q;
  assign fft_sop   = sop_q;
  assign fft_eop   = eop_q;
  assign drop_cnt  = drop_cnt_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_fft_frame_feeder.sv
// tb/tb_fft_frame_feeder.sv - randomized bench for fft_frame_feeder against a frame-queue reference model
module tb_fft_frame_feeder;
  localparam int DATA_W   = 12;
  localparam int LOG2_LEN = 3;
  localparam int FFT_LEN  = 8;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [DATA_W-1:0]   adc_data = '0;
  logic                adc_valid = 1'b0;
  logic                fft_ready = 1'b0;
  logic                fft_start, fft_valid, fft_sop, fft_eop;
  logic [DATA_W-1:0]   fft_data;
  logic [LOG2_LEN-1:0] fft_idx;
  logic [15:0]         drop_cnt, frame_cnt;

  fft_frame_feeder #(.DATA_W(DATA_W), .LOG2_LEN(LOG2_LEN), .FFT_LEN(FFT_LEN)) dut (
    .clk(clk), .rst(rst), .adc_data(adc_data), .adc_valid(adc_valid), .fft_ready(fft_ready),
    .fft_start(fft_start), .fft_valid(fft_valid), .fft_data(fft_data), .fft_idx(fft_idx),
    .fft_sop(fft_sop), .fft_eop(fft_eop), .drop_cnt(drop_cnt), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference: banks are abstracted to a count of completed, unreleased frames
  int  frames[$];
  int  partial[$];
  int  nfull = 0;
  bit  hold = 1'b0;
  int  rph = -1;
  int  exp_drop = 0, exp_frames = 0;
  int  e_start = 0, e_valid = 0, e_idx = 0, e_sop = 0, e_eop = 0, e_data = 0;
  bit  chk_en = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit v, input int d, input bit rdy);
    int nfull_pre;
    int nxt;
    bit rel;
    if (r) begin
      frames.delete();
      partial.delete();
      nfull = 0; hold = 1'b0; rph = -1; exp_drop = 0; exp_frames = 0;
      e_start = 0; e_valid = 0; e_idx = 0; e_sop = 0; e_eop = 0; e_data = 0;
      return;
    end
    nfull_pre = nfull;
    rel = (rph == FFT_LEN);
    if (rph == -1)           nxt = (rdy && nfull_pre >= 1) ? 0 : -1;
    else if (rph == FFT_LEN) nxt = -1;
    else                     nxt = rph + 1;
    if (hold) begin
      if (nfull_pre < 2) begin
        hold = 1'b0;
        if (v) partial.push_back(d);
      end else if (v && exp_drop < 65535) begin
        exp_drop++;
      end
    end else if (v) begin
      partial.push_back(d);
      if (partial.size() == FFT_LEN) begin
        foreach (partial[i]) frames.push_back(partial[i]);
        partial.delete();
        nfull++;
        if (nfull - int'(rel) >= 2) hold = 1'b1;
      end
    end
    if (rel) begin
      nfull--;
      repeat (FFT_LEN) void'(frames.pop_front());
      exp_frames = (exp_frames + 1) % 65536;
    end
    rph     = nxt;
    e_start = (nxt == 0);
    e_valid = (nxt >= 1);
    e_idx   = (nxt >= 1) ? nxt - 1 : 0;
    e_sop   = (nxt == 1);
    e_eop   = (nxt == FFT_LEN);
    e_data  = (nxt >= 1) ? frames[nxt-1] : 0;
  endtask

  task automatic cycle(input bit r, input bit v, input int d, input bit rdy);
    @(negedge clk);
    if (chk_en) begin
      check("start", fft_start, e_start);
      check("valid", fft_valid, e_valid);
      check("idx",   fft_idx,   e_idx);
      check("sop",   fft_sop,   e_sop);
      check("eop",   fft_eop,   e_eop);
      if (e_valid != 0) check("data", fft_data, e_data);
      check("drop_cnt",  drop_cnt,  exp_drop);
      check("frame_cnt", frame_cnt, exp_frames);
    end
    rst = r; adc_valid = v; adc_data = DATA_W'(d); fft_ready = rdy;
    model_step(r, v, d, rdy);
    chk_en = 1'b1;
  endtask

  task automatic drain(input int n);
    repeat (n) cycle(0, 0, 0, 1);
  endtask

  initial begin
    int  found;
    bit  v, rdy;
    int  ready_hold;

    // 1. basic frame
    cycle(1, 0, 0, 1);
    cycle(1, 0, 0, 1);
    for (int i = 1; i <= 8; i++) cycle(0, 1, i, 1);
    drain(20);
    check("t1_frame_cnt", frame_cnt, 1);

    // 2. ping-pong, 16 continuous samples
    for (int i = 0; i < 16; i++) cycle(0, 1, i, 1);
    drain(30);
    check("t2_drop", drop_cnt, 0);
    check("t2_frame_cnt", frame_cnt, 3);

    // 3. overflow with core not ready
    for (int i = 0; i < 20; i++) cycle(0, 1, i, 0);
    cycle(0, 0, 0, 0);
    check("t3_drop", drop_cnt, 4);
    check("t3_no_start", fft_valid, 0);
    drain(40);
    check("t3_frame_cnt", frame_cnt, 5);

    // 4. gapped input
    for (int i = 0; i < 8; i++) begin
      cycle(0, 1, 100 + i, 1);
      cycle(0, 0, 0, 1);
    end
    drain(20);
    check("t4_frame_cnt", frame_cnt, 6);
    check("t4_drop", drop_cnt, 4);

    // 5. reset while streaming idx 3
    for (int i = 0; i < 8; i++) cycle(0, 1, 200 + i, 1);
    found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      if (fft_valid === 1'b1 && fft_idx === 3'd3) found = 1;
      else cycle(0, 0, 0, 1);
    end
    check("t5_reached_idx3", found, 1);
    cycle(1, 0, 0, 1);
    cycle(0, 0, 0, 1);
    check("t5_eop", fft_eop, 0);
    check("t5_frame_cnt", frame_cnt, 0);
    for (int i = 0; i < 8; i++) cycle(0, 1, 300 + i, 1);
    drain(20);
    check("t5_clean_frame", frame_cnt, 1);

    // 6. writer fills a bank on the reader's eop cycle
    for (int i = 0; i < 8; i++) cycle(0, 1, 400 + i, 1);
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 1);
    for (int i = 0; i < 8; i++) cycle(0, 1, 500 + i, 1);
    for (int i = 0; i < 8; i++) cycle(0, 1, 600 + i, 1);
    drain(40);
    check("t6_drop", drop_cnt, 0);
    check("t6_frame_cnt", frame_cnt, 4);

    // random traffic with bursts of backpressure and rare resets
    ready_hold = 0;
    rdy = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if (ready_hold == 0) begin
        rdy = ($urandom_range(0, 3) != 0);
        ready_hold = $urandom_range(1, 30);
      end
      ready_hold--;
      v = ($urandom_range(0, 3) != 0);
      cycle(($urandom_range(0, 1999) == 0), v, int'($urandom_range(0, 4095)), rdy);
    end
    drain(40);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
